attn_cmd_sequencer: RTL

Upstream feeder for the SPI serializer that drives the daughter-board signal attenuators on the ZCU111.
- Accepts per-channel attenuation commands over a valid/ready interface and queues them in a small FIFO.
- Formats each command into an LSB-first frame and issues it to the serializer with a one-cycle load pulse.
- Waits for the frame to finish, then pulses the attenuator latch-enable and enforces an inter-frame gap before the next frame.

---
 rtl/attn_seq_pkg.sv | 33 +++
 rtl/attn_cmd_fifo.sv | 71 +++++++
 rtl/attn_cmd_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/attn_seq_pkg.sv
// attn_seq_pkg
//   Shared definitions for the attenuator command sequencer: the sequencer
//   state encoding, the bit offsets of the fields inside a serializer frame,
//   the "no code latched yet" shadow marker, and two small sizing helpers.
package attn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    WAIT_DONE,
    LATCH,
    GAP
  } seq_state_e;

  localparam int CODE_LSB = 0;
  localparam int CODE_W   = 7;
  localparam int CH_LSB   = 8;

  localparam logic [CODE_W-1:0] SHADOW_INVALID = 7'h7F;

  // Channel field width; a single-channel build still carries a 1-bit field.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // The shared down-counter exits its state once it reaches 0, so a state
  // that must last N cycles is loaded with N-1 (never below 0).
  function automatic logic [31:0] cnt_load(input int cycles);
    return (cycles > 0) ? 32'(cycles - 1) : 32'd0;
  endfunction

endpackage

// File: rtl/attn_cmd_fifo.sv
// attn_cmd_fifo
//   Small synchronous FIFO holding pending attenuation commands.
//   Ports:
//     clk, rst        - clock, asynchronous active-high reset (flushes queue)
//     push_i          - write request; ignored while full
//     wr_data_i       - word to enqueue
//     pop_i           - read request; ignored while empty
//     rd_data_o       - head of queue (valid while !empty_o)
//     full_o, empty_o - occupancy flags
//     count_o         - number of stored entries
module attn_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem[rd_ptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  // Storage array; contents need no reset because count_q gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged while both pointers advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/attn_cmd_sequencer.sv
// attn_cmd_sequencer
//   Queues per-channel attenuation commands and feeds them one frame at a
//   time to the attenuator SPI serializer: load strobe, wait for the shift
//   to finish, pulse the latch enable, then hold off for an inter-frame gap.
//   Ports:
//     clk, rst          - clock, asynchronous active-high reset
//     cmd_valid/ready   - command handshake (ready = queue not full)
//     cmd_ch, cmd_code  - target channel and 7-bit attenuation code
//     ser_data, ser_ld  - formatted frame and its one-cycle load strobe
//     ser_busy          - serializer is shifting the current frame
//     atten_le          - attenuator latch enable
//     busy              - frame in flight or commands pending
//     err_timeout       - sticky: serializer never acknowledged a load
//     shadow_codes      - last latched code per channel (ATTN_SHADOW_EN only)
//   Build option: define ATTN_SHADOW_EN to drop commands that would re-send
//   the code already latched on their channel.
module attn_cmd_sequencer
  import attn_seq_pkg::*;
#(
  parameter int REG_WIDTH   = 32,
  parameter int FRAME_BITS  = 24,
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int LE_CYCLES   = 16,
  parameter int GAP_CYCLES  = 49152
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ch_width(NUM_CH)-1:0] cmd_ch,
  input  logic [6:0]                  cmd_code,
  output logic [REG_WIDTH-1:0]        ser_data,
  output logic                        ser_ld,
  input  logic                        ser_busy,
  output logic                        atten_le,
  output logic                        busy,
`ifdef ATTN_SHADOW_EN
  output logic [NUM_CH*7-1:0]         shadow_codes,
`endif
  output logic                        err_timeout
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int DW    = CODE_W + CH_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] ACK_LOAD = cnt_load(ACK_TIMEOUT);
  localparam logic [31:0] LE_LOAD  = cnt_load(LE_CYCLES);
  localparam logic [31:0] GAP_LOAD = cnt_load(GAP_CYCLES);

  seq_state_e           state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [REG_WIDTH-1:0] ser_data_q, ser_data_d;
  logic                 err_timeout_q, err_timeout_d;

  logic [DW-1:0]        fifo_rd;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]     fifo_count;
  logic [CODE_W-1:0]    head_code;
  logic [CH_W-1:0]      head_ch;

  function automatic logic [REG_WIDTH-1:0] build_frame(input logic [CODE_W-1:0] code,
                                                       input logic [CH_W-1:0] ch);
    logic [REG_WIDTH-1:0] f;
    f = '0;
    f[CODE_LSB +: CODE_W] = code;
    f[CH_LSB +: CH_W]     = ch;
    for (int i = FRAME_BITS; i < REG_WIDTH; i++) begin
      f[i] = 1'b0;
    end
    return f;
  endfunction

  attn_cmd_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (cmd_valid),
    .wr_data_i ({cmd_ch, cmd_code}),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign head_code   = fifo_rd[CODE_W-1:0];
  assign head_ch     = fifo_rd[CODE_W +: CH_W];
  assign cmd_ready   = !fifo_full;
  assign ser_ld      = (state_q == LOAD);
  assign atten_le    = (state_q == LATCH);
  assign busy        = (state_q != IDLE) || (fifo_count != '0);
  assign ser_data    = ser_data_q;
  assign err_timeout = err_timeout_q;

`ifdef ATTN_SHADOW_EN
  logic [CODE_W-1:0] shadow_q [1 << CH_W];
  logic              head_redundant;
  logic              latch_entry;

  // 7F marks "nothing latched yet", so it never counts as a match and a
  // 7F command is always transmitted.
  assign head_redundant = (shadow_q[head_ch] != SHADOW_INVALID) &&
                          (shadow_q[head_ch] == head_code);
  assign latch_entry    = (state_q == WAIT_DONE) && (state_d == LATCH);

  // Remember the code of each frame at the moment its latch pulse starts;
  // the frame fields are still held in ser_data_q at that point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < (1 << CH_W); n++) begin
        shadow_q[n] <= SHADOW_INVALID;
      end
    end else if (latch_entry) begin
      shadow_q[ser_data_q[CH_LSB +: CH_W]] <= ser_data_q[CODE_LSB +: CODE_W];
    end
  end

  // Flatten the per-channel shadows, channel n at bits [7n+6:7n].
  always_comb begin
    shadow_codes = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      shadow_codes[n*CODE_W +: CODE_W] = shadow_q[n];
    end
  end
`endif

  // Next-state logic. The single down-counter is reloaded whenever a timed
  // state is entered and the state exits on the cycle it reads 0. WAIT_DONE
  // is only entered with ser_busy high, so ser_busy low there is its fall.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ser_data_d    = ser_data_q;
    err_timeout_d = err_timeout_q;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef ATTN_SHADOW_EN
          if (!head_redundant) begin
            ser_data_d = build_frame(head_code, head_ch);
            state_d    = LOAD;
          end
`else
          ser_data_d = build_frame(head_code, head_ch);
          state_d    = LOAD;
`endif
        end
      end
      LOAD: begin
        state_d = WAIT_ACK;
        cnt_d   = ACK_LOAD;
      end
      WAIT_ACK: begin
        if (ser_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == '0) begin
          err_timeout_d = 1'b1;
          state_d       = GAP;
          cnt_d         = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      WAIT_DONE: begin
        if (!ser_busy) begin
          state_d = LATCH;
          cnt_d   = LE_LOAD;
        end
      end
      LATCH: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, frame and error registers. The frame register is only
  // written on the IDLE->LOAD edge, so it holds steady between loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ser_data_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ser_data_q    <= ser_data_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule
